// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared constants, state encoding and defaults for the HUB75 receiver
package hub75_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_ADDR_W = 4;

   // Bit positions within the 6-bit {b2,g2,r2,b1,g1,r1} pixel word
   localparam int RGB_W  = 6;
   localparam int RGB_R1 = 0;
   localparam int RGB_G1 = 1;
   localparam int RGB_B1 = 2;
   localparam int RGB_R2 = 3;
   localparam int RGB_G2 = 4;
   localparam int RGB_B2 = 5;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   typedef enum logic [0:0] {
      IDLE   = ST_IDLE,
      STREAM = ST_STREAM
   } hub75_state_e;

endpackage

// File: rtl/hub75_edge_det.sv
// rtl/hub75_edge_det.sv - single-cycle rising-edge detector against a one-cycle-delayed copy
module hub75_edge_det (
   input  logic clk_in,
   input  logic rst_n,
   input  logic sig_in,
   output logic rise
);

   logic sig_q;
   logic sig_d;

   always_comb begin
      sig_d = sig_in;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/hub75_rx.sv
// rtl/hub75_rx.sv - HUB75 panel receiver: shifts columns, commits rows on latch, streams pixel beats
module hub75_rx
   import hub75_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                     clk_in,
   input  logic                     rst_n,
   input  logic                     hub_clk,
   input  logic                     hub_lat,
   input  logic [RGB_W-1:0]         hub_rgb,
   input  logic [ADDR_W-1:0]        hub_addr,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic [RGB_W-1:0]         rx_data,
   output logic [$clog2(WIDTH)-1:0] rx_col,
   output logic [ADDR_W-1:0]        rx_row,
   output logic                     rx_last,
   output logic                     row_done,
   output logic                     seq_err,
   output logic                     len_err,
   output logic                     overrun,
   input  logic                     err_clr
);

   localparam int CW = $clog2(WIDTH);
   localparam int NW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [NW-1:0] CNT_FULL = NW'(WIDTH);
   localparam logic [NW-1:0] CNT_SAT  = NW'(WIDTH + 1);

   logic clk_rise;
   logic lat_rise;

   hub75_edge_det u_clk_det (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .sig_in (hub_clk),
      .rise   (clk_rise)
   );

   hub75_edge_det u_lat_det (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .sig_in (hub_lat),
      .rise   (lat_rise)
   );

   logic [WIDTH-1:0][RGB_W-1:0] shift_q, shift_d;
   logic [WIDTH-1:0][RGB_W-1:0] hold_q, hold_d;
   logic [NW-1:0]               col_cnt_q, col_cnt_d;
   hub75_state_e                state_q, state_d;
   logic [CW-1:0]               col_q, col_d;
   logic [ADDR_W-1:0]           row_q, row_d;
   logic [ADDR_W-1:0]           prev_addr_q, prev_addr_d;
   logic                        first_q, first_d;
   logic                        row_done_q, row_done_d;
   logic                        seq_err_q, seq_err_d;
   logic                        len_err_q, len_err_d;
   logic                        overrun_q, overrun_d;

   logic [NW-1:0] cnt_shifted;
   logic          beat_take;
   logic          last_take;
   logic          take_row;
   logic          len_set;
   logic          seq_set;
   logic          ovr_set;

   always_comb begin
      shift_d = shift_q;
      if (clk_rise) begin
         shift_d = {hub_rgb, shift_q[WIDTH-1:1]};
      end

      // The count used at a latch already includes a coincident shift
      cnt_shifted = col_cnt_q;
      if (clk_rise && (col_cnt_q != CNT_SAT)) begin
         cnt_shifted = col_cnt_q + NW'(1);
      end
      col_cnt_d = lat_rise ? '0 : cnt_shifted;

      beat_take = (state_q == STREAM) && rx_ready;
      last_take = beat_take && (col_q == COL_LAST);
      take_row  = lat_rise && ((state_q == IDLE) || last_take);

      len_set = lat_rise && (cnt_shifted != CNT_FULL);
      seq_set = lat_rise && !first_q && (hub_addr != (prev_addr_q + ADDR_W'(1)));
      ovr_set = lat_rise && !take_row;

      first_d     = lat_rise ? 1'b0 : first_q;
      prev_addr_d = lat_rise ? hub_addr : prev_addr_q;

      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      hold_d     = hold_q;
      row_done_d = take_row;
      if (take_row) begin
         state_d = STREAM;
         col_d   = '0;
         row_d   = hub_addr;
         hold_d  = shift_d;
      end else if (beat_take) begin
         if (col_q == COL_LAST) begin
            state_d = IDLE;
            col_d   = '0;
         end else begin
            col_d = col_q + CW'(1);
         end
      end

      // A set in the same cycle as err_clr wins
      seq_err_d = (seq_err_q & ~err_clr) | seq_set;
      len_err_d = (len_err_q & ~err_clr) | len_set;
      overrun_d = (overrun_q & ~err_clr) | ovr_set;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         shift_q     <= '0;
         hold_q      <= '0;
         col_cnt_q   <= '0;
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         prev_addr_q <= '0;
         first_q     <= 1'b1;
         row_done_q  <= 1'b0;
         seq_err_q   <= 1'b0;
         len_err_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         col_cnt_q   <= col_cnt_d;
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         prev_addr_q <= prev_addr_d;
         first_q     <= first_d;
         row_done_q  <= row_done_d;
         seq_err_q   <= seq_err_d;
         len_err_q   <= len_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_valid = (state_q == STREAM);
   assign rx_data  = rx_valid ? hold_q[col_q] : '0;
   assign rx_col   = col_q;
   assign rx_row   = row_q;
   assign rx_last  = rx_valid && (col_q == COL_LAST);
   assign row_done = row_done_q;
   assign seq_err  = seq_err_q;
   assign len_err  = len_err_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_hub75_rx.sv
// tb/tb_hub75_rx.sv - randomized self-checking bench for hub75_rx against a queue-based row model
module tb_hub75_rx;
   import hub75_pkg::*;

   localparam int W = 32;

   logic       clk_in   = 1'b0;
   logic       rst_n    = 1'b0;
   logic       hub_clk  = 1'b0;
   logic       hub_lat  = 1'b0;
   logic [5:0] hub_rgb  = '0;
   logic [3:0] hub_addr = '0;
   logic       rx_ready = 1'b0;
   logic       err_clr  = 1'b0;

   logic       rx_valid;
   logic [5:0] rx_data;
   logic [4:0] rx_col;
   logic [3:0] rx_row;
   logic       rx_last;
   logic       row_done;
   logic       seq_err;
   logic       len_err;
   logic       overrun;

   hub75_rx #(.WIDTH(W), .ADDR_W(4)) dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .hub_clk  (hub_clk),
      .hub_lat  (hub_lat),
      .hub_rgb  (hub_rgb),
      .hub_addr (hub_addr),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .rx_data  (rx_data),
      .rx_col   (rx_col),
      .rx_row   (rx_row),
      .rx_last  (rx_last),
      .row_done (row_done),
      .seq_err  (seq_err),
      .len_err  (len_err),
      .overrun  (overrun),
      .err_clr  (err_clr)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [5:0] d;
      int         c;
      int         r;
   } beat_t;

   beat_t      m_beats[$];
   logic [5:0] m_hist[$];   // last W shifted pixels, oldest first
   int         m_cnt;
   int         m_prev_addr;
   bit         m_first, m_pclk, m_plat;
   bit         m_done, m_seq, m_len, m_ovr;
   int         ready_mode;  // 0 always ready, 1 random, 2 never
   logic [5:0] last_rgb;

   function automatic void model_reset();
      m_beats.delete();
      m_hist.delete();
      for (int i = 0; i < W; i++) m_hist.push_back(6'd0);
      m_cnt = 0; m_prev_addr = 0; m_first = 1;
      m_pclk = 0; m_plat = 0;
      m_done = 0; m_seq = 0; m_len = 0; m_ovr = 0;
   endfunction

   function automatic void model_step();
      bit cr, lr, seq_s, len_s, ovr_s;
      if (!rst_n) begin
         model_reset();
         return;
      end
      seq_s = 0; len_s = 0; ovr_s = 0;
      cr = hub_clk && !m_pclk;
      lr = hub_lat && !m_plat;
      m_pclk = hub_clk;
      m_plat = hub_lat;
      if (cr) begin
         m_hist.push_back(hub_rgb);
         void'(m_hist.pop_front());
         if (m_cnt <= W) m_cnt++;
      end
      if (m_beats.size() > 0 && rx_ready) void'(m_beats.pop_front());
      m_done = 0;
      if (lr) begin
         len_s = (m_cnt != W);
         m_cnt = 0;
         seq_s = !m_first && (int'(hub_addr) != (m_prev_addr + 1) % 16);
         m_first = 0;
         m_prev_addr = int'(hub_addr);
         if (m_beats.size() == 0) begin
            for (int k = 0; k < W; k++) m_beats.push_back('{m_hist[k], k, int'(hub_addr)});
            m_done = 1;
         end else begin
            ovr_s = 1;
         end
      end
      m_seq = (m_seq && !err_clr) || seq_s;
      m_len = (m_len && !err_clr) || len_s;
      m_ovr = (m_ovr && !err_clr) || ovr_s;
   endfunction

   task automatic compare();
      check("valid", rx_valid, m_beats.size() > 0);
      if (m_beats.size() > 0)
         check("beat", {rx_data, rx_col, rx_row, rx_last},
               {m_beats[0].d, 5'(m_beats[0].c), 4'(m_beats[0].r), m_beats[0].c == W - 1});
      check("flags", {row_done, seq_err, len_err, overrun}, {m_done, m_seq, m_len, m_ovr});
   endtask

   task automatic tick();
      case (ready_mode)
         0:       rx_ready = 1'b1;
         1:       rx_ready = 1'($urandom_range(0, 1));
         default: rx_ready = 1'b0;
      endcase
      @(posedge clk_in);
      model_step();
      @(negedge clk_in);
      compare();
   endtask

   task automatic clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   task automatic shift_col(input logic [5:0] rgb, input bit gaps);
      hub_rgb = rgb; hub_clk = 1'b1;
      tick();
      hub_clk = 1'b0; hub_rgb = 6'($urandom);
      tick();
      if (gaps && $urandom_range(0, 3) == 0) tick();
   endtask

   task automatic row_ex(input int n, input logic [3:0] addr, input bit coinc, input bit ramp, input bit gaps);
      int s;
      s = coinc ? n - 1 : n;
      for (int k = 0; k < s; k++) shift_col(ramp ? 6'(k) : 6'($urandom), gaps);
      if (coinc) begin
         last_rgb = 6'($urandom);
         hub_rgb = last_rgb; hub_clk = 1'b1;
      end
      hub_addr = addr; hub_lat = 1'b1;
      tick();
      hub_clk = 1'b0; hub_lat = 1'b0; hub_addr = 4'($urandom);
      tick();
   endtask

   task automatic drain();
      int budget;
      budget = 400;
      ready_mode = 0;
      while ((m_beats.size() > 0 || rx_valid) && budget > 0) begin
         tick();
         budget--;
      end
      check("drain_timeout", budget > 0, 1);
   endtask

   initial begin
      int budget;
      int valids;
      logic [5:0] got31;
      logic [3:0] addr;
      model_reset();
      ready_mode = 0;
      repeat (3) tick();
      check("reset_outs", {rx_valid, rx_data, rx_col, rx_row, rx_last, row_done, seq_err, len_err, overrun}, 0);
      rst_n = 1'b1;
      tick();

      // Ramp row, address 0
      row_ex(32, 4'd0, 0, 1, 0);
      drain();
      check("row0_clean", {seq_err, len_err, overrun}, 0);

      // Address sequencing with wrap
      row_ex(32, 4'd14, 0, 0, 0); drain(); clr();
      row_ex(32, 4'd15, 0, 0, 0); drain();
      row_ex(32, 4'd0, 0, 0, 0);  drain();
      check("seq_wrap_ok", seq_err, 0);
      row_ex(32, 4'd2, 0, 0, 0);  drain();
      check("seq_skip", seq_err, 1);
      clr();
      check("seq_clr", seq_err, 0);

      // Row length errors
      row_ex(31, 4'd3, 0, 0, 0); drain();
      check("len_short", len_err, 1);
      clr();
      row_ex(33, 4'd4, 0, 0, 0); drain();
      check("len_long", len_err, 1);
      row_ex(32, 4'd5, 0, 0, 0); drain();
      check("len_sticky", len_err, 1);
      clr();

      // Overrun while stalled, then a latch coincident with the last accept
      ready_mode = 2;
      row_ex(32, 4'd6, 0, 0, 0);
      row_ex(32, 4'd7, 0, 0, 0);
      check("overrun_set", overrun, 1);
      clr();
      for (int k = 0; k < 32; k++) shift_col(6'($urandom), 0);
      ready_mode = 0;
      budget = 100;
      while (m_beats.size() != 1 && budget > 0) begin
         tick();
         budget--;
      end
      check("coinc_wait", budget > 0, 1);
      hub_addr = 4'd8; hub_lat = 1'b1;
      tick();
      hub_lat = 1'b0;
      check("coinc_stream", {overrun, row_done, rx_valid, rx_col, rx_row}, {1'b0, 1'b1, 1'b1, 5'd0, 4'd8});
      drain();

      // Shift and latch on the same cycle for the 32nd pixel
      clr();
      row_ex(32, 4'd9, 1, 0, 0);
      check("coinc_len", len_err, 0);
      got31 = '0;
      budget = 100;
      ready_mode = 0;
      while (m_beats.size() > 0 && budget > 0) begin
         if (rx_valid && rx_col == 5'd31) got31 = rx_data;
         tick();
         budget--;
      end
      check("coinc_col31", got31, last_rgb);

      // Asynchronous reset mid-stream
      ready_mode = 0;
      row_ex(32, 4'd10, 0, 0, 0);
      budget = 100;
      while (!(m_beats.size() > 0 && m_beats[0].c == 10) && budget > 0) begin
         tick();
         budget--;
      end
      check("col10_wait", budget > 0, 1);
      #2 rst_n = 1'b0;
      #1 check("async_reset", {rx_valid, rx_data, rx_col, rx_row, rx_last, row_done, seq_err, len_err, overrun}, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      valids = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rx_valid) valids++;
      end
      check("post_reset_quiet", valids, 0);

      // Randomized rows: mixed lengths, addresses, back-pressure, clears
      ready_mode = 1;
      addr = 4'd0;
      for (int r = 0; r < 25; r++) begin
         int n;
         case ($urandom_range(0, 4))
            0:       n = 31;
            1:       n = 33;
            default: n = 32;
         endcase
         addr = ($urandom_range(0, 9) == 0) ? 4'($urandom) : addr + 4'd1;
         row_ex(n, addr, $urandom_range(0, 3) == 0, 0, 1);
         if ($urandom_range(0, 5) == 0) clr();
         ready_mode = 1;
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
